// File: rtl/commit_trace_tx_if.sv
// Record stream between commit_trace_tx and the trace sink.
// Valid/ready handshake carrying one typed record per transfer.
interface commit_trace_tx_if;
  logic        rec_valid;
  logic        rec_ready;
  logic [1:0]  rec_type;
  logic [15:0] rec_a;
  logic [15:0] rec_b;

  modport master (
    output rec_valid,
    output rec_type,
    output rec_a,
    output rec_b,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_type,
    input  rec_a,
    input  rec_b,
    output rec_ready
  );
endinterface

// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: captures commit events into a FIFO and
// serializes them into REG/LOAD/STORE/HALT records; keeps run stats.
module commit_trace_tx #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_wrt,
  input  logic [2:0]        wrt_reg,
  input  logic [15:0]       wrt_data,
  input  logic              mem_read,
  input  logic              mem_wrt,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       mem_data_in,
  input  logic [15:0]       mem_data_out,
  input  logic              halt,
  input  logic              icache_req,
  input  logic              icache_hit,
  input  logic              dcache_req,
  input  logic              dcache_hit,
  commit_trace_tx_if.master rec,
  output logic              trace_full,
  output logic              overflow,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  inst_cnt,
  output logic [CNT_W-1:0]  ic_req_cnt,
  output logic [CNT_W-1:0]  ic_hit_cnt,
  output logic [CNT_W-1:0]  dc_req_cnt,
  output logic [CNT_W-1:0]  dc_hit_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]  mask;
    logic [2:0]  wrtReg;
    logic [15:0] wrtData;
    logic [15:0] memAddr;
    logic [15:0] memDataIn;
    logic [15:0] memDataOut;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_t;

  entry_t     fifoMem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  entry_t     capEntry, pendEntry, pushEntry, hold;
  logic       capEn, pendValid;
  logic       empty, doPop, doPush, slotOk, active;
  logic       accept;
  logic [1:0] kind;
  logic [3:0] clrMask;
  state_t     state, nextState;

  assign capEntry = {halt, mem_wrt, mem_read, reg_wrt, wrt_reg,
                     wrt_data, mem_addr, mem_data_in, mem_data_out};

  assign empty = (wrPtr == rdPtr);
  assign trace_full = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) &&
                      (wrPtr[AW] != rdPtr[AW]);

  assign doPop = (state == IDLE) && !empty;
  assign slotOk = !trace_full || doPop;
  assign active = capEn && (|capEntry.mask);
  assign doPush = slotOk && (active || pendValid);
  assign pushEntry = pendValid ? pendEntry : capEntry;

  always_ff @(posedge clk) begin
    if (doPush) fifoMem[wrPtr[AW-1:0]] <= pushEntry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // A HALT that meets a full FIFO is parked until the next pop frees a slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      capEn     <= 1'b1;
      pendValid <= 1'b0;
      pendEntry <= '0;
      overflow  <= 1'b0;
    end else begin
      if (active && halt) capEn <= 1'b0;
      if (active && !slotOk) begin
        if (halt) begin
          pendValid <= 1'b1;
          pendEntry <= capEntry;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (pendValid && slotOk) pendValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt  <= '0;
      inst_cnt   <= '0;
      ic_req_cnt <= '0;
      ic_hit_cnt <= '0;
      dc_req_cnt <= '0;
      dc_hit_cnt <= '0;
    end else if (capEn) begin
      cycle_cnt  <= cycle_cnt + 1'b1;
      inst_cnt   <= inst_cnt +
                    {{(CNT_W-1){1'b0}}, halt | reg_wrt | mem_wrt};
      ic_req_cnt <= ic_req_cnt + {{(CNT_W-1){1'b0}}, icache_req};
      ic_hit_cnt <= ic_hit_cnt + {{(CNT_W-1){1'b0}}, icache_hit};
      dc_req_cnt <= dc_req_cnt + {{(CNT_W-1){1'b0}}, dcache_req};
      dc_hit_cnt <= dc_hit_cnt + {{(CNT_W-1){1'b0}}, dcache_hit};
    end
  end

  always_comb begin
    kind = 2'd0;
    unique casez (hold.mask)
      4'b???1: kind = 2'd0;
      4'b??10: kind = 2'd1;
      4'b?100: kind = 2'd2;
      4'b1000: kind = 2'd3;
      default: kind = 2'd0;
    endcase
  end

  assign accept = (state == EMIT) && rec.rec_ready;
  assign clrMask = hold.mask & ~(4'b0001 << kind);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (!empty) nextState = EMIT;
      EMIT: begin
        if (accept && clrMask == 4'b0000)
          nextState = (kind == 2'd3) ? DONE : IDLE;
      end
      DONE:    nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
      done <= 1'b0;
    end else begin
      if (doPop)       hold <= fifoMem[rdPtr[AW-1:0]];
      else if (accept) hold.mask <= clrMask;
      if (accept && kind == 2'd3) done <= 1'b1;
    end
  end

  always_comb begin
    rec.rec_valid = (state == EMIT);
    rec.rec_type  = 2'd0;
    rec.rec_a     = 16'h0000;
    rec.rec_b     = 16'h0000;
    if (state == EMIT) begin
      rec.rec_type = kind;
      unique case (kind)
        2'd0: begin
          rec.rec_a = {13'b0, hold.wrtReg};
          rec.rec_b = hold.wrtData;
        end
        2'd1: begin
          rec.rec_a = hold.memAddr;
          rec.rec_b = hold.memDataOut;
        end
        2'd2: begin
          rec.rec_a = hold.memAddr;
          rec.rec_b = hold.memDataIn;
        end
        default: begin
          rec.rec_a = 16'h0000;
          rec.rec_b = 16'h0000;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_commit_trace_tx.sv
// Bench for commit_trace_tx: scoreboard of expected records,
// compared as the sink accepts them, plus directed status checks.
module tb_commit_trace_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_wrt, mem_read, mem_wrt, halt;
  logic [2:0]  wrt_reg;
  logic [15:0] wrt_data, mem_addr, mem_data_in, mem_data_out;
  logic        icache_req, icache_hit, dcache_req, dcache_hit;
  logic        trace_full, overflow, done;
  logic [31:0] cycle_cnt, inst_cnt, ic_req_cnt, ic_hit_cnt;
  logic [31:0] dc_req_cnt, dc_hit_cnt;

  commit_trace_tx_if recIf ();

  commit_trace_tx #(.DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .reg_wrt(reg_wrt), .wrt_reg(wrt_reg), .wrt_data(wrt_data),
    .mem_read(mem_read), .mem_wrt(mem_wrt), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .halt(halt),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .rec(recIf.master),
    .trace_full(trace_full), .overflow(overflow), .done(done),
    .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt),
    .ic_req_cnt(ic_req_cnt), .ic_hit_cnt(ic_hit_cnt),
    .dc_req_cnt(dc_req_cnt), .dc_hit_cnt(dc_hit_cnt)
  );

  typedef struct {
    logic [1:0]  t;
    logic [15:0] a;
    logic [15:0] b;
  } rec_t;

  rec_t expQ[$];
  int   nChecks = 0;
  int   nFails = 0;
  int   edges = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) edges = 0;
    else      edges++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expRec(input logic [1:0] t, input logic [15:0] a,
                        input logic [15:0] b);
    rec_t r;
    r.t = t;
    r.a = a;
    r.b = b;
    expQ.push_back(r);
  endtask

  task automatic idleIn();
    reg_wrt = 0; mem_read = 0; mem_wrt = 0; halt = 0;
    wrt_reg = 0; wrt_data = 0; mem_addr = 0;
    mem_data_in = 0; mem_data_out = 0;
    icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
  endtask

  task automatic drive(input logic rw, input logic [2:0] wr,
                       input logic [15:0] wd, input logic mr,
                       input logic mw, input logic [15:0] ad,
                       input logic [15:0] di, input logic [15:0] dout,
                       input logic h);
    reg_wrt = rw; wrt_reg = wr; wrt_data = wd;
    mem_read = mr; mem_wrt = mw; mem_addr = ad;
    mem_data_in = di; mem_data_out = dout; halt = h;
    @(posedge clk);
    #1;
    idleIn();
  endtask

  task automatic rstDut();
    rst = 0;
    expQ.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic drain(input int maxCyc);
    int n = 0;
    while (expQ.size() != 0 && n < maxCyc) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_left", expQ.size(), 0);
  endtask

  // Sink side: every accepted record must match the scoreboard head.
  always @(negedge clk) begin
    if (rst && recIf.rec_valid && recIf.rec_ready) begin
      if (expQ.size() == 0) begin
        check("unexpected_rec", {14'b0, recIf.rec_type, recIf.rec_a}, 32'hFFFF_FFFF);
      end else begin
        rec_t e;
        e = expQ.pop_front();
        check("rec_type", recIf.rec_type, e.t);
        check("rec_a", recIf.rec_a, e.a);
        check("rec_b", recIf.rec_b, e.b);
        if (e.t == 2'd3) begin
          check("done_before_halt_acc", done, 0);
          @(posedge clk);
          #1;
          check("done_after_halt_acc", done, 1);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int haltEdges;
    idleIn();
    recIf.rec_ready = 1'b0;
    rstDut();

    check("rst_valid", recIf.rec_valid, 0);
    check("rst_type", recIf.rec_type, 0);
    check("rst_a", recIf.rec_a, 0);
    check("rst_b", recIf.rec_b, 0);
    check("rst_full", trace_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_done", done, 0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_inst", inst_cnt, 0);

    // Single register write and its latency
    recIf.rec_ready = 1'b1;
    expRec(2'd0, 16'h0003, 16'h1234);
    drive(1, 3'd3, 16'h1234, 0, 0, 0, 0, 0, 0);
    check("lat_edge_k", recIf.rec_valid, 0);
    check("inst_one", inst_cnt, 1);
    @(posedge clk); #1;
    check("lat_edge_k1", recIf.rec_valid, 1);
    drain(20);

    // Load with writeback: REG then LOAD back-to-back
    expRec(2'd0, 16'h0005, 16'hBEEF);
    expRec(2'd1, 16'h0040, 16'hBEEF);
    drive(1, 3'd5, 16'hBEEF, 1, 0, 16'h0040, 0, 16'hBEEF, 0);
    @(posedge clk); #1;
    check("ld_first_type", recIf.rec_type, 0);
    @(posedge clk); #1;
    check("ld_second_valid", recIf.rec_valid, 1);
    check("ld_second_type", recIf.rec_type, 1);
    drain(20);

    // Backpressure: 10 stores, the 10th is dropped
    recIf.rec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) expRec(2'd2, 16'h0100 + i[15:0], 16'hA000 + i[15:0]);
      drive(0, 0, 0, 0, 1, 16'h0100 + i[15:0], 16'hA000 + i[15:0], 0, 0);
      if (i == 3) begin
        check("bp_held_type", recIf.rec_type, 2);
        check("bp_held_a", recIf.rec_a, 16'h0100);
      end
    end
    check("bp_valid", recIf.rec_valid, 1);
    check("bp_stable_a", recIf.rec_a, 16'h0100);
    check("bp_stable_b", recIf.rec_b, 16'hA000);
    check("bp_full", trace_full, 1);
    check("bp_ovf", overflow, 1);
    recIf.rec_ready = 1'b1;
    drain(60);
    check("bp_ovf_sticky", overflow, 1);

    // Reset while a REG+STORE entry is being emitted
    recIf.rec_ready = 1'b0;
    drive(1, 3'd2, 16'h0055, 0, 1, 16'h0010, 16'h0066, 0, 0);
    @(posedge clk); #1;
    check("mr_valid_pre", recIf.rec_valid, 1);
    check("mr_a_pre", recIf.rec_a, 16'h0002);
    #2 rst = 0;
    #1;
    check("mr_valid", recIf.rec_valid, 0);
    check("mr_a", recIf.rec_a, 0);
    check("mr_b", recIf.rec_b, 0);
    check("mr_ovf", overflow, 0);
    check("mr_inst", inst_cnt, 0);
    check("mr_cycle", cycle_cnt, 0);
    @(posedge clk); #1;
    rst = 1;
    recIf.rec_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("mr_no_rec", recIf.rec_valid, 0);

    // Counters, then HALT freezes them
    for (int i = 0; i < 5; i++) begin
      icache_req = 1;
      icache_hit = (i % 2 == 0);
      dcache_req = (i < 2);
      dcache_hit = (i == 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    expRec(2'd3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    haltEdges = edges;
    check("cnt_cycle", cycle_cnt, haltEdges);
    check("cnt_ic_req", ic_req_cnt, 5);
    check("cnt_ic_hit", ic_hit_cnt, 3);
    check("cnt_dc_req", dc_req_cnt, 2);
    check("cnt_dc_hit", dc_hit_cnt, 1);
    check("cnt_inst", inst_cnt, 1);
    icache_req = 1;
    repeat (3) @(posedge clk);
    #1;
    idleIn();
    check("frz_cycle", cycle_cnt, haltEdges);
    check("frz_ic_req", ic_req_cnt, 5);
    drain(20);
    check("cnt_done", done, 1);

    // HALT arriving on a full FIFO
    rstDut();
    recIf.rec_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      expRec(2'd0, {13'b0, i[2:0]}, 16'h0200 + i[15:0]);
      drive(1, i[2:0], 16'h0200 + i[15:0], 0, 0, 0, 0, 0, 0);
    end
    check("hf_full", trace_full, 1);
    expRec(2'd3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("hf_inst", inst_cnt, 10);
    check("hf_ovf", overflow, 0);
    drive(1, 3'd7, 16'hDEAD, 0, 0, 0, 0, 0, 0);
    drive(1, 3'd6, 16'hBEEF, 0, 0, 0, 0, 0, 0);
    check("hf_inst_frz", inst_cnt, 10);
    check("hf_ovf_late", overflow, 0);
    check("hf_done_pre", done, 0);
    recIf.rec_ready = 1'b1;
    drain(100);
    check("hf_done", done, 1);
    repeat (5) @(posedge clk);
    #1;
    check("hf_quiet", recIf.rec_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end
endmodule
